// File: rtl/rrf_alloc_if.sv
// Dispatch/commit/flush bundle between the rename stage and the rrf_alloc tag allocator.
// master drives requests, commit info and flush; slave (the allocator) returns tags and status.
interface rrf_alloc_if #(
   parameter int RRF_SEL = 6
);
   logic               stall_dp_i;
   logic               req1_i;
   logic               req2_i;
   logic [1:0]         com_inst_num_i;
   logic [RRF_SEL-1:0] commit_ptr_i;
   logic               prmiss_i;
   logic [RRF_SEL-1:0] rrftag_fix_i;
   logic [RRF_SEL-1:0] dp1_addr_o;
   logic [RRF_SEL-1:0] dp2_addr_o;
   logic               allocatable_o;
   logic [RRF_SEL-1:0] rrfptr_o;
   logic               nextrrfcyc_o;
   logic [RRF_SEL:0]   freenum_o;

   modport master (
      output stall_dp_i, req1_i, req2_i, com_inst_num_i, commit_ptr_i, prmiss_i, rrftag_fix_i,
      input  dp1_addr_o, dp2_addr_o, allocatable_o, rrfptr_o, nextrrfcyc_o, freenum_o
   );

   modport slave (
      input  stall_dp_i, req1_i, req2_i, com_inst_num_i, commit_ptr_i, prmiss_i, rrftag_fix_i,
      output dp1_addr_o, dp2_addr_o, allocatable_o, rrfptr_o, nextrrfcyc_o, freenum_o
   );
endinterface

// File: rtl/rrf_alloc.sv
// Dual-dispatch ring-buffer tag allocator for rename-register/ROB entries with mispredict rewind.
// Optional stall statistics counter enabled by defining RRF_ALLOC_STATS_EN.
module rrf_alloc #(
   parameter int RRF_NUM = 64,
   parameter int RRF_SEL = 6
) (
   input  logic        clk,
   input  logic        reset,
   rrf_alloc_if.slave  bus
`ifdef RRF_ALLOC_STATS_EN
   ,
   output logic [31:0] alloc_stall_cnt_o
`endif
);

   localparam logic [RRF_SEL:0] LP_FULL = (RRF_SEL+1)'(RRF_NUM);

   logic [RRF_SEL-1:0] r_rrfptr;
   logic               r_nextrrfcyc;
   logic [RRF_SEL:0]   r_freenum;

   logic [1:0]         w_reqcnt;
   logic               w_allocatable;
   logic               w_alloc_go;
   logic [1:0]         w_alloc_amt;
   logic [RRF_SEL-1:0] w_ptr_add;
   logic               w_ptr_carry;
   logic [RRF_SEL+1:0] w_free_sum;
   logic [RRF_SEL:0]   w_free_nxt;
   logic [RRF_SEL-1:0] w_fix_used;
   logic [RRF_SEL:0]   w_fix_free;

   assign w_reqcnt      = {1'b0, bus.req1_i} + {1'b0, bus.req2_i};
   assign w_allocatable = r_freenum >= {{(RRF_SEL-1){1'b0}}, w_reqcnt};
   assign w_alloc_go    = (w_reqcnt != 2'd0) && w_allocatable && !bus.stall_dp_i && !bus.prmiss_i;
   assign w_alloc_amt   = w_alloc_go ? w_reqcnt : 2'd0;

   assign {w_ptr_carry, w_ptr_add} = {1'b0, r_rrfptr} + {{(RRF_SEL-1){1'b0}}, w_alloc_amt};

   // Illegal over-commit would overflow the count; clamp rather than wrap.
   assign w_free_sum = {1'b0, r_freenum} - {{RRF_SEL{1'b0}}, w_alloc_amt}
                     + {{RRF_SEL{1'b0}}, bus.com_inst_num_i};
   assign w_free_nxt = (w_free_sum > {1'b0, LP_FULL}) ? LP_FULL : w_free_sum[RRF_SEL:0];

   // Live entries after the flush are those between the post-commit head and the fix tag.
   assign w_fix_used = bus.rrftag_fix_i - bus.commit_ptr_i
                     - {{(RRF_SEL-2){1'b0}}, bus.com_inst_num_i};
   assign w_fix_free = LP_FULL - {1'b0, w_fix_used};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rrfptr     <= '0;
         r_nextrrfcyc <= 1'b0;
         r_freenum    <= LP_FULL;
      end else if (bus.prmiss_i) begin
         r_rrfptr     <= bus.rrftag_fix_i;
         r_nextrrfcyc <= r_nextrrfcyc ^ (bus.rrftag_fix_i > r_rrfptr);
         r_freenum    <= w_fix_free;
      end else begin
         r_rrfptr     <= w_ptr_add;
         r_nextrrfcyc <= r_nextrrfcyc ^ w_ptr_carry;
         r_freenum    <= w_free_nxt;
      end
   end

   assign bus.dp1_addr_o    = r_rrfptr;
   assign bus.dp2_addr_o    = bus.req1_i ? (r_rrfptr + RRF_SEL'(1)) : r_rrfptr;
   assign bus.allocatable_o = w_allocatable;
   assign bus.rrfptr_o      = r_rrfptr;
   assign bus.nextrrfcyc_o  = r_nextrrfcyc;
   assign bus.freenum_o     = r_freenum;

`ifdef RRF_ALLOC_STATS_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if ((w_reqcnt != 2'd0) && !w_allocatable && !bus.prmiss_i) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign alloc_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rrf_alloc.sv
// Self-checking bench for rrf_alloc: directed scenarios with literal expectations,
// then randomized dispatch/commit/flush traffic checked against a ring-occupancy model.
module tb_rrf_alloc;
   localparam int N = 64;

   logic clk;
   logic reset;

   rrf_alloc_if #(.RRF_SEL(6)) bus ();

`ifdef RRF_ALLOC_STATS_EN
   logic [31:0] alloc_stall_cnt_o;
`endif

   rrf_alloc #(.RRF_NUM(64), .RRF_SEL(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef RRF_ALLOC_STATS_EN
      ,
      .alloc_stall_cnt_o (alloc_stall_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: next tag, wrap parity, free count, stall-event count.
   int m_ptr, m_cyc, m_free, m_stall;
   int n_chk, n_fail;

   // Latched inputs for the current cycle's model update.
   bit c_st, c_r1, c_r2, c_pm;
   int c_com, c_fix, c_cp;

   function automatic int m_used();
      return N - m_free;
   endfunction

   function automatic int m_head();
      return (m_ptr - m_used() + N) % N;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      int rc;
      rc = int'(c_r1) + int'(c_r2);
      chk("rrfptr",      int'(bus.rrfptr_o),      m_ptr);
      chk("nextrrfcyc",  int'(bus.nextrrfcyc_o),  m_cyc);
      chk("freenum",     int'(bus.freenum_o),     m_free);
      chk("allocatable", int'(bus.allocatable_o), (m_free >= rc) ? 1 : 0);
      chk("dp1",         int'(bus.dp1_addr_o),    m_ptr);
      chk("dp2",         int'(bus.dp2_addr_o),    c_r1 ? (m_ptr + 1) % N : m_ptr);
`ifdef RRF_ALLOC_STATS_EN
      chk("stall_cnt",   int'(alloc_stall_cnt_o), m_stall);
`endif
   endtask

   task automatic apply(input bit st, input bit r1, input bit r2, input int com,
                        input bit pm, input int fix);
      @(negedge clk);
      c_st = st; c_r1 = r1; c_r2 = r2; c_com = com; c_pm = pm; c_fix = fix;
      c_cp = m_head();
      bus.stall_dp_i     = st;
      bus.req1_i         = r1;
      bus.req2_i         = r2;
      bus.com_inst_num_i = com[1:0];
      bus.commit_ptr_i   = c_cp[5:0];
      bus.prmiss_i       = pm;
      bus.rrftag_fix_i   = fix[5:0];
      #1;
      compare_outputs();
   endtask

   task automatic clk_edge();
      int rc, a, np;
      @(posedge clk);
      rc = int'(c_r1) + int'(c_r2);
      if (rc != 0 && m_free < rc && !c_pm) m_stall++;
      if (c_pm) begin
         m_free = N - ((c_fix - c_cp - c_com + 2 * N) % N);
         if (c_fix > m_ptr) m_cyc ^= 1;
         m_ptr = c_fix;
      end else begin
         a = (rc != 0 && m_free >= rc && !c_st) ? rc : 0;
         np = m_ptr + a;
         if (np >= N) m_cyc ^= 1;
         m_ptr = np % N;
         m_free = m_free - a + c_com;
         if (m_free > N) m_free = N;
      end
   endtask

   task automatic step(input bit st, input bit r1, input bit r2, input int com,
                       input bit pm, input int fix);
      apply(st, r1, r2, com, pm, fix);
      clk_edge();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.stall_dp_i = 1'b0; bus.req1_i = 1'b0; bus.req2_i = 1'b0;
      bus.com_inst_num_i = 2'd0; bus.commit_ptr_i = '0;
      bus.prmiss_i = 1'b0; bus.rrftag_fix_i = '0;
      repeat (2) @(posedge clk);
      m_ptr = 0; m_cyc = 0; m_free = N; m_stall = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int com, k, used;
      bit st, r1, r2, pm;
      n_chk = 0; n_fail = 0;
      c_st = 0; c_r1 = 0; c_r2 = 0; c_pm = 0; c_com = 0; c_fix = 0; c_cp = 0;
      do_reset();

      // T1: idle after reset
      apply(0, 0, 0, 0, 0, 0);
      chk("t1_rrfptr", int'(bus.rrfptr_o), 0);
      chk("t1_freenum", int'(bus.freenum_o), 64);
      chk("t1_alloc", int'(bus.allocatable_o), 1);
      chk("t1_cyc", int'(bus.nextrrfcyc_o), 0);
      clk_edge();

      // T2: three dual allocations
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 1, 0, 0, 0);
         chk("t2_dp1", int'(bus.dp1_addr_o), 2 * i);
         chk("t2_dp2", int'(bus.dp2_addr_o), 2 * i + 1);
         clk_edge();
      end
      apply(0, 0, 0, 0, 0, 0);
      chk("t2_rrfptr", int'(bus.rrfptr_o), 6);
      chk("t2_freenum", int'(bus.freenum_o), 58);
      clk_edge();

      // T3: stalled dual request holds everything
      for (int i = 0; i < 2; i++) begin
         apply(1, 1, 1, 0, 0, 0);
         chk("t3_dp1", int'(bus.dp1_addr_o), 6);
         chk("t3_dp2", int'(bus.dp2_addr_o), 7);
         clk_edge();
      end
      apply(0, 0, 0, 0, 0, 0);
      chk("t3_rrfptr", int'(bus.rrfptr_o), 6);
      chk("t3_freenum", int'(bus.freenum_o), 58);
      clk_edge();

      // T4: fill, blocked single request, commit 2, then dual succeeds
      for (int i = 0; i < 29; i++) step(0, 1, 1, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0);
      chk("t4_full_free", int'(bus.freenum_o), 0);
      chk("t4_full_alloc", int'(bus.allocatable_o), 0);
      clk_edge();
      apply(0, 1, 1, 2, 0, 0);
      chk("t4_nobypass", int'(bus.allocatable_o), 0);
      clk_edge();
      apply(0, 1, 1, 0, 0, 0);
      chk("t4_free2", int'(bus.freenum_o), 2);
      chk("t4_alloc2", int'(bus.allocatable_o), 1);
      chk("t4_dp1", int'(bus.dp1_addr_o), 0);
      clk_edge();
      apply(0, 0, 0, 0, 0, 0);
      chk("t4_after_free", int'(bus.freenum_o), 0);
      chk("t4_after_ptr", int'(bus.rrfptr_o), 2);
      clk_edge();

      // T5: drain, walk pointer to 63, dual allocation across the wrap
      for (int i = 0; i < 32; i++) step(0, 0, 0, 2, 0, 0);
      for (int i = 0; i < 30; i++) step(0, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 0, 0);
      chk("t5_dp1", int'(bus.dp1_addr_o), 63);
      chk("t5_dp2", int'(bus.dp2_addr_o), 0);
      chk("t5_cyc_before", int'(bus.nextrrfcyc_o), 1);
      clk_edge();
      apply(0, 0, 0, 0, 0, 0);
      chk("t5_rrfptr", int'(bus.rrfptr_o), 1);
      chk("t5_cyc_after", int'(bus.nextrrfcyc_o), 0);
      clk_edge();

      // T6: mispredict rewind with a commit and a dropped dual request
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 2, 0, 0);
      apply(0, 1, 1, 1, 1, 5);
      chk("t6_cp", int'(bus.commit_ptr_i), 2);
      chk("t6_ptr_pre", int'(bus.rrfptr_o), 10);
      clk_edge();
      apply(0, 0, 0, 0, 0, 0);
      chk("t6_rrfptr", int'(bus.rrfptr_o), 5);
      chk("t6_freenum", int'(bus.freenum_o), 62);
      chk("t6_cyc", int'(bus.nextrrfcyc_o), 0);
      clk_edge();

`ifdef RRF_ALLOC_STATS_EN
      // T7: three blocked cycles while full
      do_reset();
      for (int i = 0; i < 32; i++) step(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0);
      chk("t7_stall_cnt", int'(alloc_stall_cnt_o), 3);
      clk_edge();
`endif

      // Random traffic; commits never exceed the live count, flush tags stay inside the window.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         used = m_used();
         st = ($urandom_range(0, 3) == 0);
         r1 = $urandom_range(0, 1);
         r2 = $urandom_range(0, 1);
         com = $urandom_range(0, 2);
         if ((i / 500) % 2 == 1 && $urandom_range(0, 1) == 0) com = 0;
         if (com > used) com = used;
         pm = ($urandom_range(0, 24) == 0);
         k = pm ? $urandom_range(0, used - com) : 0;
         step(st, r1, r2, com, pm, (m_head() + com + k) % N);
      end
      apply(0, 0, 0, 0, 0, 0);
      clk_edge();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
